// File: rtl/cpu_controller_if.sv
// Controller-to-datapath/memory bundle: memory command bus, datapath strobes and status returns.
// The controller side is the master modport; the datapath and memory side is the slave modport.
interface cpu_controller_if;
    logic [15:0] mem_rdata;
    logic [15:0] datapath_out;
    logic [2:0]  Z_out;
    logic [8:0]  R7toPC;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [8:0]  PC;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  vsel;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic        halted;

    // Strobes are single-cycle levels: they are valid for the whole cycle in which the FSM sits
    // in the owning state, and there is no back-pressure on either side.
    modport master (
        input  mem_rdata, datapath_out, Z_out, R7toPC,
        output mem_cmd, mem_addr, PC, sximm8, sximm5, readnum, writenum, vsel,
        output write, loada, loadb, loadc, loads, asel, bsel, shift, ALUop, halted
    );
    modport slave (
        output mem_rdata, datapath_out, Z_out, R7toPC,
        input  mem_cmd, mem_addr, PC, sximm8, sximm5, readnum, writenum, vsel,
        input  write, loada, loadb, loadc, loads, asel, bsel, shift, ALUop, halted
    );
endinterface

// File: rtl/cpu_controller.sv
// Fetch/decode/control FSM for the simple RISC datapath; owns PC and IR, all outputs registered.
// Optional macro CPU_CTRL_INSN_COUNT_EN adds the retired-instruction counter output insn_count.
module cpu_controller #(
    parameter logic [8:0] RESET_PC = 9'd0
) (
    input  logic             clk,
    input  logic             reset,
    cpu_controller_if.master bus,
    output logic [4:0]       state_dbg
`ifdef CPU_CTRL_INSN_COUNT_EN
    ,
    output logic [15:0]      insn_count
`endif
);
    typedef enum logic [4:0] {
        S_RST, S_FETCH, S_LOAD_IR, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_EXEC,
        S_WRITE_C, S_ADDR, S_ALATCH, S_MEM_RD, S_MEM_WAIT, S_WRITE_M, S_GET_D, S_DATA,
        S_MEM_WR, S_BRANCH, S_BL_LINK, S_BX_RD, S_HALT
    } state_t;

    typedef struct packed {
        logic [1:0] mem_cmd;
        logic [8:0] mem_addr;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic [1:0] vsel;
        logic       write, loada, loadb, loadc, loads, asel, bsel;
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic       halted;
    } ctl_t;

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    state_t      state, nxt;
    ctl_t        ctl, ctl_nxt;
    logic [15:0] ir, sximm8;
    logic [8:0]  pc, pc_nxt, addr_reg, addr_nxt;
    logic        br_take, cond_true, retire;
    logic [2:0]  opcode, rn, rd, rm;
    logic [1:0]  op, sh;
    logic        is_alu, is_mov_reg, is_mvn, is_cmp;

    assign opcode     = ir[15:13];
    assign op         = ir[12:11];
    assign rn         = ir[10:8];
    assign rd         = ir[7:5];
    assign sh         = ir[4:3];
    assign rm         = ir[2:0];
    assign sximm8     = {{8{ir[7]}}, ir[7:0]};
    assign is_alu     = (opcode == 3'b101);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign is_cmp     = is_alu && (op == 2'b01);

    // Z_out bits: [0]=Z, [1]=N, [2]=V
    always_comb begin
        case (rn)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = bus.Z_out[0];
            3'b010:  cond_true = !bus.Z_out[0];
            3'b011:  cond_true = bus.Z_out[1] ^ bus.Z_out[2];
            3'b100:  cond_true = (bus.Z_out[1] ^ bus.Z_out[2]) | bus.Z_out[0];
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            S_RST:      nxt = S_FETCH;
            S_FETCH:    nxt = S_LOAD_IR;
            S_LOAD_IR:  nxt = S_DECODE;
            S_DECODE: begin
                case ({opcode, op})
                    5'b110_10:          nxt = S_WRITE_IMM;
                    5'b110_00:          nxt = S_GET_B;
                    5'b011_00, 5'b100_00: nxt = S_GET_A;
                    5'b010_11:          nxt = S_BL_LINK;
                    5'b010_00:          nxt = S_BX_RD;
                    default:            nxt = S_HALT;
                endcase
                if (is_alu) nxt = is_mvn ? S_GET_B : S_GET_A;
                if (opcode == 3'b001) nxt = S_BRANCH;
            end
            S_GET_A:    nxt = is_alu ? S_GET_B : S_ADDR;
            S_GET_B:    nxt = S_EXEC;
            S_EXEC:     nxt = is_cmp ? S_FETCH : S_WRITE_C;
            S_ADDR:     nxt = S_ALATCH;
            S_ALATCH:   nxt = (opcode == 3'b011) ? S_MEM_RD : S_GET_D;
            S_MEM_RD:   nxt = S_MEM_WAIT;
            S_MEM_WAIT: nxt = S_WRITE_M;
            S_GET_D:    nxt = S_DATA;
            S_DATA:     nxt = S_MEM_WR;
            S_HALT:     nxt = S_HALT;
            default:    nxt = S_FETCH;
        endcase
    end

    // PC only moves in the final state of an instruction; 9-bit arithmetic wraps naturally.
    always_comb begin
        retire = (nxt == S_FETCH) && (state != S_RST);
        pc_nxt = pc;
        if (retire) begin
            case (state)
                S_BRANCH:  pc_nxt = br_take ? (pc + 9'd1 + sximm8[8:0]) : (pc + 9'd1);
                S_BL_LINK: pc_nxt = pc + 9'd1 + sximm8[8:0];
                S_BX_RD:   pc_nxt = bus.R7toPC;
                default:   pc_nxt = pc + 9'd1;
            endcase
        end
        addr_nxt = (state == S_ALATCH) ? bus.datapath_out[8:0] : addr_reg;
    end

    // Outputs are decoded from the state being entered so they register alongside it.
    always_comb begin
        ctl_nxt = '0;
        ctl_nxt.mem_addr = pc_nxt;
        case (nxt)
            S_FETCH, S_LOAD_IR: ctl_nxt.mem_cmd = CMD_READ;
            S_WRITE_IMM: begin ctl_nxt.vsel = 2'd1; ctl_nxt.writenum = rn; ctl_nxt.write = 1'b1; end
            S_GET_A:     begin ctl_nxt.readnum = rn; ctl_nxt.loada = 1'b1; end
            S_GET_B:     begin ctl_nxt.readnum = rm; ctl_nxt.loadb = 1'b1; end
            S_EXEC: begin
                ctl_nxt.shift  = sh;
                ctl_nxt.loadc  = 1'b1;
                ctl_nxt.alu_op = is_alu ? op : 2'b00;
                ctl_nxt.asel   = is_mov_reg | is_mvn;
                ctl_nxt.loads  = is_cmp;
            end
            S_WRITE_C:   begin ctl_nxt.vsel = 2'd3; ctl_nxt.writenum = rd; ctl_nxt.write = 1'b1; end
            S_ADDR:      begin ctl_nxt.bsel = 1'b1; ctl_nxt.loadc = 1'b1; end
            S_MEM_RD, S_MEM_WAIT: begin ctl_nxt.mem_cmd = CMD_READ; ctl_nxt.mem_addr = addr_nxt; end
            S_WRITE_M:   begin ctl_nxt.writenum = rd; ctl_nxt.write = 1'b1; end
            S_GET_D:     begin ctl_nxt.readnum = rd; ctl_nxt.loadb = 1'b1; end
            S_DATA:      begin ctl_nxt.asel = 1'b1; ctl_nxt.loadc = 1'b1; end
            S_MEM_WR:    begin ctl_nxt.mem_cmd = CMD_WRITE; ctl_nxt.mem_addr = addr_nxt; end
            S_BL_LINK:   begin ctl_nxt.vsel = 2'd2; ctl_nxt.writenum = 3'd7; ctl_nxt.write = 1'b1; end
            S_BX_RD:     ctl_nxt.readnum = rd;
            S_HALT:      ctl_nxt.halted = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_RST;
            pc           <= RESET_PC;
            ir           <= '0;
            addr_reg     <= '0;
            br_take      <= 1'b0;
            ctl          <= '0;
            ctl.mem_addr <= RESET_PC;
        end else begin
            state    <= nxt;
            pc       <= pc_nxt;
            addr_reg <= addr_nxt;
            ctl      <= ctl_nxt;
            if (state == S_LOAD_IR) ir <= bus.mem_rdata;
            if (state == S_DECODE) br_take <= cond_true;
        end
    end

`ifdef CPU_CTRL_INSN_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) insn_count <= '0;
        else if (retire) insn_count <= insn_count + 16'd1;
    end
`endif

    assign state_dbg    = state;
    assign bus.PC       = pc;
    assign bus.sximm8   = sximm8;
    assign bus.sximm5   = {{11{ir[4]}}, ir[4:0]};
    assign bus.mem_cmd  = ctl.mem_cmd;
    assign bus.mem_addr = ctl.mem_addr;
    assign bus.readnum  = ctl.readnum;
    assign bus.writenum = ctl.writenum;
    assign bus.vsel     = ctl.vsel;
    assign bus.write    = ctl.write;
    assign bus.loada    = ctl.loada;
    assign bus.loadb    = ctl.loadb;
    assign bus.loadc    = ctl.loadc;
    assign bus.loads    = ctl.loads;
    assign bus.asel     = ctl.asel;
    assign bus.bsel     = ctl.bsel;
    assign bus.shift    = ctl.shift;
    assign bus.ALUop    = ctl.alu_op;
    assign bus.halted   = ctl.halted;
endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: per-instruction cycle-by-cycle expectation model plus directed and random programs.
// Honours CPU_CTRL_INSN_COUNT_EN when it is defined for the build.
module tb_cpu_controller;
    localparam logic [8:0] RESET_PC = 9'd0;

    typedef struct packed {
        logic [15:0] cnt;
        logic [15:0] sx8;
        logic [15:0] sx5;
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [8:0]  pc;
        logic [2:0]  rnum;
        logic [2:0]  wnum;
        logic [1:0]  vsel;
        logic        wr, la, lb, lc, ls, as, bs;
        logic [1:0]  sh;
        logic [1:0]  alu;
        logic        halt;
    } rec_t;
    localparam int W = $bits(rec_t);

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] state_dbg;
`ifdef CPU_CTRL_INSN_COUNT_EN
    logic [15:0] insn_count;
`endif
    always #5 clk = ~clk;

    cpu_controller_if bus();

    cpu_controller #(.RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
`ifdef CPU_CTRL_INSN_COUNT_EN
        ,
        .insn_count(insn_count)
`endif
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic [8:0]  m_pc;
    logic [15:0] m_sx8, m_sx5, m_cnt;

    function automatic rec_t base();
        rec_t r;
        r = '0;
`ifdef CPU_CTRL_INSN_COUNT_EN
        r.cnt = m_cnt;
`endif
        r.sx8 = m_sx8;
        r.sx5 = m_sx5;
        r.addr = m_pc;
        r.pc = m_pc;
        return r;
    endfunction

    function automatic rec_t dut_rec();
        rec_t a;
        a = '0;
`ifdef CPU_CTRL_INSN_COUNT_EN
        a.cnt = insn_count;
`endif
        a.sx8 = bus.sximm8;   a.sx5 = bus.sximm5;
        a.cmd = bus.mem_cmd;  a.addr = bus.mem_addr; a.pc = bus.PC;
        a.rnum = bus.readnum; a.wnum = bus.writenum; a.vsel = bus.vsel;
        a.wr = bus.write;     a.la = bus.loada;      a.lb = bus.loadb;
        a.lc = bus.loadc;     a.ls = bus.loads;      a.as = bus.asel;
        a.bs = bus.bsel;      a.sh = bus.shift;      a.alu = bus.ALUop;
        a.halt = bus.halted;
        return a;
    endfunction

    // compare process: one expected record per cycle, sampled mid-cycle
    always @(negedge clk) begin : cmp_blk
        rec_t e, a;
        if (exp_q.size() != 0) begin
            e = rec_t'(exp_q.pop_front());
            a = dut_rec();
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL cycle t=%0t state=%0d got=%h exp=%h", $time, state_dbg, a, e);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, act, expv);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout left=%0d state=%0d", exp_q.size(), state_dbg);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        m_pc = RESET_PC;
        m_sx8 = '0;
        m_sx5 = '0;
        m_cnt = '0;
        exp_q.push_back(base());
        drain();
        reset = 1'b0;
    endtask

    // Builds the whole expected cycle sequence of one instruction, then drives it.
    // cut > 0 keeps only the first cut cycles (the caller then resets mid-instruction).
    task automatic run_insn(input logic [15:0] w, input logic [2:0] z, input logic [15:0] dout,
                            input logic [8:0] r7, input int cut);
        rec_t seq[$];
        rec_t r;
        logic [2:0] opc, rn, rd;
        logic [1:0] op;
        logic [8:0] off, npc;
        logic halt, taken, movr, mvn, cmp;
        opc = w[15:13]; op = w[12:11]; rn = w[10:8]; rd = w[7:5];
        off = {w[7], w[7:0]};
        npc = m_pc + 9'd1;
        halt = 1'b0;
        r = base(); r.cmd = 2'b01;
        seq.push_back(r);
        seq.push_back(r);
        m_sx8 = {{8{w[7]}}, w[7:0]};
        m_sx5 = {{11{w[4]}}, w[4:0]};
        seq.push_back(base());
        if (opc == 3'b110 && op == 2'b10) begin
            r = base(); r.vsel = 2'd1; r.wnum = rn; r.wr = 1'b1; seq.push_back(r);
        end else if (opc == 3'b101 || (opc == 3'b110 && op == 2'b00)) begin
            movr = (opc == 3'b110);
            mvn = (opc == 3'b101) && (op == 2'b11);
            cmp = (opc == 3'b101) && (op == 2'b01);
            if (!(movr || mvn)) begin
                r = base(); r.rnum = rn; r.la = 1'b1; seq.push_back(r);
            end
            r = base(); r.rnum = w[2:0]; r.lb = 1'b1; seq.push_back(r);
            r = base(); r.sh = w[4:3]; r.lc = 1'b1; r.alu = movr ? 2'b00 : op;
            r.as = movr || mvn; r.ls = cmp; seq.push_back(r);
            if (!cmp) begin
                r = base(); r.vsel = 2'd3; r.wnum = rd; r.wr = 1'b1; seq.push_back(r);
            end
        end else if ((opc == 3'b011 || opc == 3'b100) && op == 2'b00) begin
            r = base(); r.rnum = rn; r.la = 1'b1; seq.push_back(r);
            r = base(); r.bs = 1'b1; r.lc = 1'b1; seq.push_back(r);
            seq.push_back(base());
            if (opc == 3'b011) begin
                r = base(); r.cmd = 2'b01; r.addr = dout[8:0];
                seq.push_back(r);
                seq.push_back(r);
                r = base(); r.wnum = rd; r.wr = 1'b1; seq.push_back(r);
            end else begin
                r = base(); r.rnum = rd; r.lb = 1'b1; seq.push_back(r);
                r = base(); r.as = 1'b1; r.lc = 1'b1; seq.push_back(r);
                r = base(); r.cmd = 2'b10; r.addr = dout[8:0]; seq.push_back(r);
            end
        end else if (opc == 3'b001) begin
            case (rn)
                3'd0:    taken = 1'b1;
                3'd1:    taken = z[0];
                3'd2:    taken = !z[0];
                3'd3:    taken = (z[1] != z[2]);
                3'd4:    taken = (z[1] != z[2]) || z[0];
                default: taken = 1'b0;
            endcase
            seq.push_back(base());
            if (taken) npc = m_pc + 9'd1 + off;
        end else if (opc == 3'b010 && op == 2'b11) begin
            r = base(); r.vsel = 2'd2; r.wnum = 3'd7; r.wr = 1'b1; seq.push_back(r);
            npc = m_pc + 9'd1 + off;
        end else if (opc == 3'b010 && op == 2'b00) begin
            r = base(); r.rnum = rd; seq.push_back(r);
            npc = r7;
        end else begin
            halt = 1'b1;
            r = base(); r.halt = 1'b1;
            repeat (20) seq.push_back(r);
        end
        for (int i = 0; i < seq.size() && (cut == 0 || i < cut); i++) exp_q.push_back(seq[i]);
        @(posedge clk);
        #1;
        bus.mem_rdata = w;
        bus.Z_out = z;
        bus.datapath_out = dout;
        bus.R7toPC = r7;
        drain();
        if (cut == 0 && !halt) begin
            m_pc = npc;
            m_cnt = m_cnt + 16'd1;
        end
        if (halt) do_reset();
    endtask

    task automatic run_random();
        logic [15:0] w;
        logic [15:0] rnd;
        rnd = 16'($urandom);
        case ($urandom_range(0, 8))
            0:       w = {5'b110_10, rnd[10:0]};
            1:       w = {3'b101, rnd[12:0]};
            2:       w = {5'b110_00, rnd[10:0]};
            3:       w = {5'b011_00, rnd[10:0]};
            4:       w = {5'b100_00, rnd[10:0]};
            5:       w = {3'b001, rnd[12:0]};
            6:       w = {5'b010_11, rnd[10:0]};
            7:       w = {5'b010_00, rnd[10:0]};
            default: w = rnd;
        endcase
        run_insn(w, 3'($urandom), 16'($urandom), 9'($urandom), 0);
    endtask

    initial begin
        bus.mem_rdata = '0;
        bus.datapath_out = '0;
        bus.Z_out = '0;
        bus.R7toPC = '0;
        m_pc = RESET_PC; m_sx8 = '0; m_sx5 = '0; m_cnt = '0;
        @(negedge clk);
        #1;
        do_reset();
        chk("reset_mem_cmd", {14'd0, bus.mem_cmd}, 16'h0000);
        chk("reset_pc", {7'd0, bus.PC}, 16'h0000);

        run_insn(16'hD007, 3'b000, 16'h0000, 9'h000, 0);   // MOV R0,#7
        chk("mov_imm_pc", {7'd0, m_pc}, 16'h0001);
        run_insn(16'hA148, 3'b000, 16'h0000, 9'h000, 0);   // ADD R2,R1,R0,LSL#1
        repeat (3) run_insn(16'hD103, 3'b000, 16'h0000, 9'h000, 0);
        run_insn(16'h2102, 3'b001, 16'h0000, 9'h000, 0);   // BEQ +2 taken at PC=5
        chk("beq_taken_pc", {7'd0, m_pc}, 16'h0008);
        run_insn(16'h40E0, 3'b000, 16'h0000, 9'h005, 0);   // BX R7 -> 5
        run_insn(16'h2102, 3'b000, 16'h0000, 9'h000, 0);   // BEQ not taken
        chk("beq_not_taken_pc", {7'd0, m_pc}, 16'h0006);
        run_insn(16'h40E0, 3'b000, 16'h0000, 9'h004, 0);
        run_insn(16'h20FF, 3'b000, 16'h0000, 9'h000, 0);   // B -1 at PC=4
        chk("b_self_pc", {7'd0, m_pc}, 16'h0004);
        run_insn(16'h6162, 3'b000, 16'h0012, 9'h000, 0);   // LDR R3,[R1,#2]
        run_insn(16'h8162, 3'b000, 16'h0034, 9'h000, 0);   // STR R3,[R1,#2]
        run_insn(16'hA9C8, 3'b000, 16'h0000, 9'h000, 0);   // CMP
        run_insn(16'hC0A2, 3'b000, 16'h0000, 9'h000, 0);   // MOV R5,R2
        run_insn(16'h40E0, 3'b000, 16'h0000, 9'h05A, 0);
        chk("bx_pc", {7'd0, m_pc}, 16'h005A);
        run_insn(16'h40E0, 3'b000, 16'h0000, 9'h1FF, 0);
        run_insn(16'h5FFE, 3'b000, 16'h0000, 9'h000, 0);   // BL -2 at PC=0x1FF
        chk("bl_wrap_pc", {7'd0, m_pc}, 16'h01FE);
        run_insn(16'hE000, 3'b000, 16'h0000, 9'h000, 0);   // HALT, then reset

        for (int i = 0; i < 300; i++) run_random();

        run_insn(16'h6162, 3'b000, 16'h0055, 9'h000, 8);   // stop in MEM_WAIT
        do_reset();
        run_insn(16'hD007, 3'b000, 16'h0000, 9'h000, 0);
        chk("post_abort_pc", {7'd0, m_pc}, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
